// File: rtl/switch_pkg.sv
// Shared defaults and sizing helper for the switch input bank.
package switch_pkg;

  localparam int SW_WIDTH       = 8;
  localparam int SW_SYNC_STAGES = 2;
  localparam int SW_DEBOUNCE    = 4;

  // Ceiling log2, never below 1, so a counter always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/switch_debounce_ch.sv
// One switch channel: synchroniser chain, mismatch counter, stable level
// and rise/fall pulses of the stable (pre-inversion) level.
module switch_debounce_ch
  import switch_pkg::*;
#(
  parameter int SYNC_STAGES     = SW_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic hold,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int             CW      = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_q;
  logic [CW-1:0]          cnt;

  assign sync_q = sync[SYNC_STAGES-1];

  // Final qualifying mismatch; hold overrides it so a frozen channel never flips.
  assign accept = !hold && (sync_q != stable) && (cnt == CNT_MAX);

  // Synchroniser keeps shifting through hold so the level is fresh when hold drops.
  always_ff @(posedge clk) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], din};
  end

  // Debounce counter, stable level and single-cycle edge pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= accept & ~stable;
      fall <= accept &  stable;
      if (hold || (sync_q == stable)) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_inv_bank.sv
// Bank of WIDTH debounced switch inputs with per-channel inversion and
// rise/fall/changed pulses referenced to the inverted output level.
module switch_inv_bank
  import switch_pkg::*;
#(
  parameter int               WIDTH           = SW_WIDTH,
  parameter int               SYNC_STAGES     = SW_SYNC_STAGES,
  parameter int               DEBOUNCE_CYCLES = SW_DEBOUNCE,
  parameter logic [WIDTH-1:0] INV_MASK        = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             hold,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] s_rise;
  logic [WIDTH-1:0] s_fall;
  logic [WIDTH-1:0] accept;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    switch_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (in[g]),
      .hold  (hold),
      .stable(stable[g]),
      .rise  (s_rise[g]),
      .fall  (s_fall[g]),
      .accept(accept[g])
    );
  end

  // Inversion of a register by a constant mask: out stays register-driven.
  assign out = stable ^ INV_MASK;

  // An inverted channel sees its stable rising edge as a falling output edge.
  assign rise = (s_rise & ~INV_MASK) | (s_fall & INV_MASK);
  assign fall = (s_fall & ~INV_MASK) | (s_rise & INV_MASK);

  // Bank-wide change pulse, registered on the same edge as rise/fall.
  always_ff @(posedge clk) begin
    if (!rst_n) changed <= 1'b0;
    else        changed <= |accept;
  end

endmodule

// File: tb/tb_switch_inv_bank.sv
// Self-checking bench for switch_inv_bank: directed scenarios plus a
// randomized run against a window-based behavioural model.
module tb_switch_inv_bank;

  localparam int         W  = 8;
  localparam int         S  = 2;
  localparam int         D  = 4;
  localparam logic [7:0] M1 = 8'hFF;
  localparam logic [7:0] M2 = 8'h0F;
  localparam int         NC = 8192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] in = 8'h00;
  logic [7:0] out, rise, fall, out2, rise2, fall2;
  logic       changed, changed2;

  int tests = 0;
  int fails = 0;

  switch_inv_bank dut (
    .clk(clk), .rst_n(rst_n), .in(in), .hold(hold),
    .out(out), .rise(rise), .fall(fall), .changed(changed)
  );

  switch_inv_bank #(.INV_MASK(M2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in(in), .hold(hold),
    .out(out2), .rise(rise2), .fall(fall2), .changed(changed2)
  );

  always #5 clk = ~clk;

  // Model: a channel flips at edge e when the D synced samples seen at
  // edges e-D+1..e all differ from its stable level, none of those edges
  // had hold, and the window starts after the last reset/flip of that channel.
  // The synced sample at edge e is the input present at edge e-S (zero if
  // that edge was not after the last reset).
  int         cyc = 0;
  bit   [7:0] in_h   [NC];
  bit         hold_h [NC];
  int         last_rst = 0;
  int         last_acc [W];
  logic [7:0] m_stable = 8'h00;
  logic [7:0] m_acc = 8'h00;

  function automatic logic [7:0] e_out(input logic [7:0] m);
    return m_stable ^ m;
  endfunction
  function automatic logic [7:0] e_rise(input logic [7:0] m);
    return m_acc & (m_stable ^ m);
  endfunction
  function automatic logic [7:0] e_fall(input logic [7:0] m);
    return m_acc & ~(m_stable ^ m);
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    if (cyc >= NC) begin
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, NC);
      $fatal(1, "cycle budget exceeded");
    end
    in_h[cyc]   = in;
    hold_h[cyc] = hold;
    if (!rst_n) begin
      m_stable = '0;
      m_acc    = '0;
      last_rst = cyc;
      for (int i = 0; i < W; i++) last_acc[i] = cyc;
    end else begin
      for (int i = 0; i < W; i++) begin
        bit ok;
        ok = (cyc - D >= last_rst) && (cyc - D >= last_acc[i]);
        for (int k = 0; k < D && ok; k++) begin
          int  ee;
          bit  smp;
          ee  = cyc - k;
          smp = 1'b0;
          if (ee - S >= last_rst + 1) smp = in_h[ee - S][i];
          if (hold_h[ee] || (smp == m_stable[i])) ok = 1'b0;
        end
        m_acc[i] = ok;
        if (ok) begin
          m_stable[i] = ~m_stable[i];
          last_acc[i] = cyc;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in    = 8'hFF;
    step();
    step();
    tests++; if (out !== 8'hFF) begin fails++; $display("FAIL reset_out: got %h want ff", out); end
    tests++; if ((rise | fall) !== 8'h00) begin fails++; $display("FAIL reset_pulse: got %h/%h want 00", rise, fall); end
    tests++; if (changed !== 1'b0) begin fails++; $display("FAIL reset_changed: got %b want 0", changed); end
    tests++; if (out2 !== M2) begin fails++; $display("FAIL reset_out_mask: got %h want %h", out2, M2); end
    rst_n = 1'b1;
    in    = 8'h00;
    for (int n = 0; n < 8; n++) begin
      step();
      tests++; if (out !== 8'hFF) begin fails++; $display("FAIL reset_idle_out: cycle %0d got %h want ff", n, out); end
    end
  endtask

  task automatic test_clean_press();
    int         lat = 0;
    logic [7:0] o = 'x, f = 'x, fnext = 'x;
    logic       ch = 1'bx;
    in[0] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (lat != 0 && n == lat + 1) fnext = fall;
      if (lat == 0 && out[0] == 1'b0) begin
        lat = n; o = out; f = fall; ch = changed;
      end
    end
    tests++; if (lat != S + D) begin fails++; $display("FAIL press_latency: got %0d want %0d", lat, S + D); end
    tests++; if (o !== 8'hFE) begin fails++; $display("FAIL press_out: got %h want fe", o); end
    tests++; if (f !== 8'h01) begin fails++; $display("FAIL press_fall: got %h want 01", f); end
    tests++; if (ch !== 1'b1) begin fails++; $display("FAIL press_changed: got %b want 1", ch); end
    tests++; if (fnext !== 8'h00) begin fails++; $display("FAIL press_fall_width: got %h want 00", fnext); end
  endtask

  task automatic test_bounce();
    logic [7:0] p = 8'h00;
    int         lat = 0;
    in[3] = 1'b1; step(); p |= rise | fall; step(); p |= rise | fall;
    in[3] = 1'b0; step(); p |= rise | fall; step(); p |= rise | fall;
    in[3] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (lat == 0) begin
        if (out[3] == 1'b0) lat = n;
        else p |= rise | fall;
      end
    end
    tests++; if (p !== 8'h00) begin fails++; $display("FAIL bounce_glitch: got pulses %h want 00", p); end
    tests++; if (lat != S + D) begin fails++; $display("FAIL bounce_latency: got %0d want %0d", lat, S + D); end
  endtask

  task automatic test_hold();
    logic frozen = 1'b1;
    int   lat = 0;
    in[1] = 1'b1;
    for (int n = 0; n < 5; n++) step();
    hold = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      if (out[1] !== 1'b1 || changed !== 1'b0) frozen = 1'b0;
    end
    hold = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (lat == 0 && out[1] == 1'b0) lat = n;
    end
    tests++; if (frozen !== 1'b1) begin fails++; $display("FAIL hold_frozen: got %b want 1", frozen); end
    tests++; if (lat != D) begin fails++; $display("FAIL hold_release_latency: got %0d want %0d", lat, D); end
  endtask

  task automatic test_mask();
    int         lat = 0, npulse = 0;
    logic [7:0] o = 'x, r = 'x, f = 'x;
    rst_n = 1'b0; in = 8'h00; step();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) step();
    tests++; if (out2 !== 8'h0F) begin fails++; $display("FAIL mask_idle: got %h want 0f", out2); end
    in = 8'hFF;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (changed2 === 1'b1) begin
        npulse++;
        if (lat == 0) begin lat = n; o = out2; r = rise2; f = fall2; end
      end
    end
    tests++; if (lat != S + D) begin fails++; $display("FAIL mask_latency: got %0d want %0d", lat, S + D); end
    tests++; if (o !== 8'hF0) begin fails++; $display("FAIL mask_out: got %h want f0", o); end
    tests++; if (r !== 8'hF0) begin fails++; $display("FAIL mask_rise: got %h want f0", r); end
    tests++; if (f !== 8'h0F) begin fails++; $display("FAIL mask_fall: got %h want 0f", f); end
    tests++; if (npulse != 1) begin fails++; $display("FAIL mask_changed_count: got %0d want 1", npulse); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] p = 8'h00;
    int         lat = 0;
    rst_n = 1'b0; in = 8'h00; step();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) step();
    in = 8'h04;
    for (int n = 0; n < 4; n++) begin step(); p |= rise | fall; end
    rst_n = 1'b0; step(); p |= rise | fall;
    rst_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (lat == 0) begin
        if (out[2] == 1'b0) lat = n;
        else p |= rise | fall;
      end
    end
    tests++; if (p !== 8'h00) begin fails++; $display("FAIL rstmid_pulse: got %h want 00", p); end
    tests++; if (lat != S + D) begin fails++; $display("FAIL rstmid_latency: got %0d want %0d", lat, S + D); end
  endtask

  task automatic test_random();
    rst_n = 1'b0; hold = 1'b0; in = 8'h00; step();
    rst_n = 1'b1;
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 7) == 0) in[i] = ~in[i];
      hold  = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
      tests++;
      if ({out, rise, fall, changed} !== {e_out(M1), e_rise(M1), e_fall(M1), |m_acc}) begin
        fails++;
        $display("FAIL rand_bank: cycle %0d got out=%h rise=%h fall=%h chg=%b want out=%h rise=%h fall=%h chg=%b",
                 n, out, rise, fall, changed, e_out(M1), e_rise(M1), e_fall(M1), |m_acc);
      end
      tests++;
      if ({out2, rise2, fall2, changed2} !== {e_out(M2), e_rise(M2), e_fall(M2), |m_acc}) begin
        fails++;
        $display("FAIL rand_bank_mask: cycle %0d got out=%h rise=%h fall=%h chg=%b want out=%h rise=%h fall=%h chg=%b",
                 n, out2, rise2, fall2, changed2, e_out(M2), e_rise(M2), e_fall(M2), |m_acc);
      end
    end
    rst_n = 1'b1; hold = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < W; i++) last_acc[i] = 0;
    #2;
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold();
    test_mask();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
